rx_psdu_deframer: RTL and testbench
===================================

// Module: rx_psdu_deframer
// PURPOSE
//   Receive-side stage directly downstream of the descrambler in the 802.11a RX chain.
//   Takes the serial descrambled bit stream, captures and checks the 16-bit SERVICE field,
//   and packs the following PSDU bits LSB-first into bytes.
//   Stops after LENGTH bytes, which discards tail and pad bits.
//   Signals the end of the frame to the MAC-side byte consumer.
// PARAMETERS
//   LEN_W         12   width of the length input; maximum PSDU is 2**LEN_W-1 bytes
//   SERVICE_BITS  16   number of SERVICE bits preceding the PSDU
//   SCR_BITS      7    leading SERVICE bits that must descramble to zero
// PORTS
//   clk          in   1       single clock; all logic is rising-edge
//   reset        in   1       synchronous, active-high reset
//   start        in   1       one-cycle pulse; begins a frame and latches length
//   length       in   LEN_W   PSDU length in bytes; sampled only when start=1
//   bit_valid    in   1       data_in is a valid descrambled bit this cycle
//   data_in      in   1       serial descrambled bit from the descrambler
//   byte_out     out  8       assembled PSDU byte; first received bit -> byte_out[0]
//   byte_valid   out  1       byte_out is valid; one-cycle pulse
//   frame_done   out  1       one-cycle pulse; the frame completed normally
//   busy         out  1       high in SERVICE and DATA states
//   service_out  out  16      captured SERVICE field, LSB = first received bit
//   service_err  out  1       high if any of SERVICE bits [SCR_BITS-1:0] was 1; sticky
// BEHAVIOUR
//   Reset: state=IDLE; all outputs=0; bit, byte and length counters cleared.
//   All outputs are registered. Every output change is visible in the cycle after the causing edge.
//   States: IDLE -> SERVICE -> DATA -> IDLE.
//   IDLE
//     - bit_valid and data_in are ignored.
//     - On start=1: latch length; clear service_out, service_err and the counters.
//     - Go to SERVICE.
//   The data_in bit in the start cycle is NOT consumed. The first SERVICE bit is the first
//   bit_valid=1 cycle after start.
//   SERVICE
//     - Each bit_valid=1 cycle shifts data_in into service_out[bit_cnt] and increments bit_cnt.
//     - If bit_cnt < SCR_BITS and data_in=1, set service_err.
//     - On the edge that samples bit 16:
//         latched length == 0 -> pulse frame_done, go to IDLE.
//         otherwise           -> go to DATA with bit_cnt=0.
//   DATA
//     - Each bit_valid=1 cycle places data_in in shift position bit_cnt[2:0].
//     - On the edge that samples the 8th bit of a byte:
//         byte_out = full byte, byte_valid = 1 for exactly one cycle, byte_cnt + 1.
//     - If the new byte_cnt == latched length, frame_done pulses in the same cycle as
//       that byte_valid, and the state goes to IDLE.
//     - Tail and pad bits after the last byte fall into IDLE and are ignored.
//   bit_valid=0 in any state: hold all state. byte_valid and frame_done return to 0.
//   byte_out holds its last value between pulses.
//   busy is high in SERVICE and DATA, low in IDLE.
//   service_out and service_err hold until the next start or reset.
//   Boundary conditions:
//     - start in SERVICE or DATA: abort the current frame with no frame_done, relatch length,
//       clear counters, service_out and service_err, and go to SERVICE.
//       start has priority over a bit on the same edge.
//     - reset mid-frame: same as power-up reset; a partial byte is dropped.
//     - length = 2**LEN_W-1: byte_cnt is LEN_W bits wide and does not wrap before completion.
//   Throughput: one bit per cycle; no backpressure. The downstream consumer must accept
//   every byte_valid pulse.
// TESTING
//   1. reset; start with length=3; 16 zero SERVICE bits, then 0xA5,0x3C,0xFF LSB-first
//      -> byte_valid x3 with those values, frame_done with 3rd byte, busy=0 afterward.
//   2. SERVICE bit 2 = 1, length=1, byte 0x81 -> service_err=1, service_out=16'h0004,
//      byte 0x81 still delivered with frame_done.
//   3. Test 1 with bit_valid toggling 1/0 every cycle -> identical bytes; each byte_valid
//      appears the cycle after the 8th valid bit is sampled.
//   4. start with length=0 -> frame_done the cycle after the 16th SERVICE bit; no byte_valid;
//      extra bits ignored.
//   5. length=4, start re-asserted after the 1st byte -> no frame_done for the aborted frame;
//      new frame (length=2, 0x12,0x34) delivers exactly 2 bytes plus frame_done.
//   6. reset asserted mid-DATA -> all outputs 0 the next cycle; following bits ignored until
//      start.

Source files
------------

// File: rtl/rx_psdu_deframer.sv
// Post-descrambler deframer: captures and checks SERVICE, then packs PSDU bits LSB-first into
// bytes. It stops after the latched byte count, so tail and pad bits are dropped.
module rx_psdu_deframer #(
    parameter int LEN_W        = 12,
    parameter int SERVICE_BITS = 16,
    parameter int SCR_BITS     = 7
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [LEN_W-1:0]        length,
    input  logic                    bit_valid,
    input  logic                    data_in,
    output logic [7:0]              byte_out,
    output logic                    byte_valid,
    output logic                    frame_done,
    output logic                    busy,
    output logic [SERVICE_BITS-1:0] service_out,
    output logic                    service_err
);

    localparam int              BC_W     = $clog2(SERVICE_BITS);
    localparam logic [BC_W-1:0] SVC_LAST = BC_W'(SERVICE_BITS - 1);
    localparam logic [BC_W-1:0] SCR_LIM  = BC_W'(SCR_BITS);

    typedef enum logic [1:0] {IDLE, SERVICE, DATA} state_t;

    state_t           state;
    logic [BC_W-1:0]  bit_cnt;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] byte_cnt;
    logic [LEN_W-1:0] byte_cnt_nxt;
    logic [6:0]       shreg;

    // The top bit of a byte is never stored. It goes straight into byte_out.
    assign byte_cnt_nxt = byte_cnt + LEN_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            len_q       <= '0;
            byte_cnt    <= '0;
            shreg       <= '0;
            byte_out    <= '0;
            byte_valid  <= 1'b0;
            frame_done  <= 1'b0;
            busy        <= 1'b0;
            service_out <= '0;
            service_err <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_done <= 1'b0;
            if (start) begin
                // A restart wins over any bit on this edge. It also abandons a frame in flight.
                state       <= SERVICE;
                len_q       <= length;
                bit_cnt     <= '0;
                byte_cnt    <= '0;
                shreg       <= '0;
                service_out <= '0;
                service_err <= 1'b0;
                busy        <= 1'b1;
            end else begin
                case (state)
                    SERVICE: begin
                        if (bit_valid) begin
                            service_out[bit_cnt] <= data_in;
                            if (bit_cnt < SCR_LIM && data_in)
                                service_err <= 1'b1;
                            if (bit_cnt == SVC_LAST) begin
                                bit_cnt <= '0;
                                if (len_q == '0) begin
                                    frame_done <= 1'b1;
                                    busy       <= 1'b0;
                                    state      <= IDLE;
                                end else begin
                                    state <= DATA;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + BC_W'(1);
                            end
                        end
                    end
                    DATA: begin
                        if (bit_valid) begin
                            if (bit_cnt[2:0] == 3'd7) begin
                                byte_out   <= {data_in, shreg};
                                byte_valid <= 1'b1;
                                byte_cnt   <= byte_cnt_nxt;
                                bit_cnt    <= '0;
                                if (byte_cnt_nxt == len_q) begin
                                    frame_done <= 1'b1;
                                    busy       <= 1'b0;
                                    state      <= IDLE;
                                end
                            end else begin
                                shreg[bit_cnt[2:0]] <= data_in;
                                bit_cnt             <= bit_cnt + BC_W'(1);
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rx_psdu_deframer.sv
// Bench for rx_psdu_deframer: directed table plus random frames. Expectations come from the
// index of each valid bit within the frame's serial stream.
module tb_rx_psdu_deframer;

    localparam int LEN_W = 12;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [LEN_W-1:0] length = '0;
    logic             bit_valid = 1'b0;
    logic             data_in = 1'b0;
    logic [7:0]       byte_out;
    logic             byte_valid;
    logic             frame_done;
    logic             busy;
    logic [15:0]      service_out;
    logic             service_err;

    rx_psdu_deframer #(.LEN_W(LEN_W), .SERVICE_BITS(16), .SCR_BITS(7)) dut (
        .clk(clk), .reset(reset), .start(start), .length(length),
        .bit_valid(bit_valid), .data_in(data_in), .byte_out(byte_out),
        .byte_valid(byte_valid), .frame_done(frame_done), .busy(busy),
        .service_out(service_out), .service_err(service_err)
    );

    always #5 clk = ~clk;

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] byte_q[$];
    logic [7:0] last_byte = 8'h00;

    typedef struct {
        int          len;
        logic [15:0] svc;
        logic [7:0]  b0, b1, b2;
        int          mode;
        bit          exp_err;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Valid-bit pattern: 0 = every cycle, 1 = every other cycle, 2 = random (about 2/3 of cycles).
    function automatic bit pick_valid(input int mode, input int cyc);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (cyc % 2) == 0;
        return $urandom_range(0, 2) != 0;
    endfunction

    // Starts a frame and drives it. stop_after>0 stops after that many valid bits (partial frame).
    // Otherwise it drives the full frame plus random pad bits.
    task automatic run_frame(input int len, input logic [15:0] svc, input int mode,
                             input int stop_after, input bit chk_err, input bit exp_err);
        int          n = 16 + 8 * len;
        int          total = (stop_after > 0) ? stop_after : n + int'($urandom_range(0, 12));
        int          k = 0;
        int          cyc = 0;
        bit          v, d, ev_byte, ev_done;
        logic [15:0] mask;
        start = 1'b1; length = LEN_W'(len); bit_valid = 1'b1; data_in = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_svc", 32'(service_out), 32'd0);
        chk("start_err", 32'(service_err), 32'd0);
        chk("start_bv", 32'(byte_valid), 32'd0);
        chk("start_done", 32'(frame_done), 32'd0);
        while (k < total) begin
            v = pick_valid(mode, cyc);
            cyc++;
            if (!v) d = 1'($urandom);
            else if (k < 16) d = svc[k];
            else if (k < n) d = byte_q[(k - 16) / 8][(k - 16) % 8];
            else d = 1'($urandom);
            bit_valid = v; data_in = d;
            @(posedge clk); #1;
            if (v) k++;
            ev_byte = v && k > 16 && k <= n && ((k - 16) % 8) == 0;
            ev_done = v && k == n;
            if (ev_byte) last_byte = byte_q[(k - 16) / 8 - 1];
            mask = (k >= 16) ? 16'hFFFF : 16'((32'd1 << k) - 1);
            chk("byte_valid", 32'(byte_valid), 32'(ev_byte));
            chk("frame_done", 32'(frame_done), 32'(ev_done));
            chk("busy", 32'(busy), 32'(k < n));
            chk("byte_out", 32'(byte_out), 32'(last_byte));
            chk("service_out", 32'(service_out), 32'(svc & mask));
            chk("service_err", 32'(service_err), 32'(|(svc & mask & 16'h007F)));
        end
        bit_valid = 1'b0;
        if (chk_err) chk("tbl_err", 32'(service_err), 32'(exp_err));
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_bo"}, 32'(byte_out), 32'd0);
        chk({name, "_bv"}, 32'(byte_valid), 32'd0);
        chk({name, "_fd"}, 32'(frame_done), 32'd0);
        chk({name, "_busy"}, 32'(busy), 32'd0);
        chk({name, "_svc"}, 32'(service_out), 32'd0);
        chk({name, "_err"}, 32'(service_err), 32'd0);
    endtask

    initial begin
        tbl[0] = '{3, 16'h0000, 8'hA5, 8'h3C, 8'hFF, 0, 1'b0};
        tbl[1] = '{1, 16'h0004, 8'h81, 8'h00, 8'h00, 0, 1'b1};
        tbl[2] = '{3, 16'h0000, 8'hA5, 8'h3C, 8'hFF, 1, 1'b0};
        tbl[3] = '{0, 16'hFF80, 8'h00, 8'h00, 8'h00, 0, 1'b0};
        tbl[4] = '{2, 16'h0040, 8'h5A, 8'hC3, 8'h00, 2, 1'b1};
        tbl[5] = '{2, 16'h0080, 8'h01, 8'h80, 8'h00, 2, 1'b0};

        // power-up reset
        bit_valid = 1'b1; data_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        reset = 1'b0;
        // IDLE ignores bits
        repeat (5) @(posedge clk);
        #1;
        chk_all_zero("idle");
        bit_valid = 1'b0;

        foreach (tbl[i]) begin
            byte_q = {tbl[i].b0, tbl[i].b1, tbl[i].b2};
            run_frame(tbl[i].len, tbl[i].svc, tbl[i].mode, 0, 1'b1, tbl[i].exp_err);
        end

        // abort after the first byte, then a new shorter frame
        byte_q = {8'h55, 8'hAA, 8'h0F, 8'hF0};
        run_frame(4, 16'h0000, 0, 16 + 8 + 3, 1'b0, 1'b0);
        byte_q = {8'h12, 8'h34};
        run_frame(2, 16'h0000, 0, 0, 1'b0, 1'b0);

        // reset mid-DATA drops the partial byte and returns everything to zero
        byte_q = {8'hDE, 8'hAD, 8'hBE};
        run_frame(3, 16'h0300, 0, 16 + 10, 1'b0, 1'b0);
        reset = 1'b1; bit_valid = 1'b1; data_in = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        last_byte = 8'h00;
        chk_all_zero("midreset");
        for (int c = 0; c < 30; c++) begin
            bit_valid = 1'b1; data_in = 1'($urandom);
            @(posedge clk); #1;
            chk_all_zero("postreset");
        end
        bit_valid = 1'b0;

        // random frames
        for (int f = 0; f < 25; f++) begin
            int          len = int'($urandom_range(0, 8));
            logic [15:0] svc = 16'($urandom);
            if ($urandom_range(0, 1) == 0) svc[6:0] = 7'd0;
            byte_q.delete();
            for (int b = 0; b < len; b++) byte_q.push_back(8'($urandom));
            run_frame(len, svc, int'($urandom_range(0, 2)), 0, 1'b0, 1'b0);
        end

        // maximum length: the byte counter must reach 4095 without wrapping
        byte_q.delete();
        for (int b = 0; b < 4095; b++) byte_q.push_back(8'($urandom));
        run_frame(4095, 16'h0000, 0, 0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
